// File: rtl/pvz_pkg.sv
// Shared constants and types for the zombie lane engine: colours, visible
// origin of the pixel counters, the game FSM state and a span helper.
package pvz_pkg;

    localparam logic [11:0] COL_BLACK      = 12'h000;
    localparam logic [11:0] COL_RED        = 12'hF00;
    localparam logic [11:0] COL_GREY       = 12'h0B4;
    localparam logic [11:0] COL_GREEN      = 12'h0F0;
    localparam logic [11:0] COL_PLANT      = 12'h070;
    localparam logic [11:0] COL_LIGHT_GREY = 12'h332;

    // Pixel counter values of the first visible column and row.
    localparam logic [9:0] H_ORG = 10'd144;
    localparam logic [9:0] V_ORG = 10'd35;

    typedef enum logic {
        ST_PLAY = 1'b0,
        ST_OVER = 1'b1
    } game_state_e;

    // True when pos lies in [lo, lo+len). All operands are 11 bits so the
    // upper bound never wraps for on-screen coordinates.
    function automatic logic in_span(input logic [10:0] pos,
                                     input logic [10:0] lo,
                                     input logic [10:0] len);
        return (pos >= lo) && (pos < lo + len);
    endfunction

endpackage

// File: rtl/lane_tracker.sv
// One lane of the game: a single zombie walking left and a single pea flying
// right. State only moves when advance is high (frame tick while playing).
// kill and reached_plant describe what the coming advance will do, so the
// top can count kills and end the game on the same edge.
module lane_tracker
    import pvz_pkg::*;
#(
    parameter int ZOMBIE_STEP = 1,
    parameter int PEA_STEP    = 4,
    parameter int SCREEN_W    = 640,
    parameter int PLANT_X     = 16,
    parameter int PLANT_W     = 32,
    parameter int ZOMBIE_W    = 32,
    parameter int PEA_W       = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       advance,
    input  logic       spawn,
    input  logic       fire,
    output logic       zombie_act,
    output logic [9:0] zombie_x,
    output logic       pea_act,
    output logic [9:0] pea_x,
    output logic       kill,
    output logic       reached_plant
);

    localparam logic [10:0] Z_STEP     = 11'(ZOMBIE_STEP);
    localparam logic [10:0] P_STEP     = 11'(PEA_STEP);
    localparam logic [10:0] P_WIDTH    = 11'(PEA_W);
    localparam logic [10:0] P_LIMIT    = 11'(SCREEN_W - PEA_W);
    localparam logic [10:0] PLANT_EDGE = 11'(PLANT_X + PLANT_W);
    localparam logic [9:0]  Z_SPAWN_X  = 10'(SCREEN_W - ZOMBIE_W);
    localparam logic [9:0]  P_START_X  = 10'(PLANT_X + PLANT_W);

    logic        hit;
    logic        z_alive;
    logic        p_alive;
    logic [10:0] z_moved;
    logic [10:0] p_moved;
    logic        zombie_act_d;
    logic [9:0]  zombie_x_d;
    logic        pea_act_d;
    logic [9:0]  pea_x_d;

    // Next lane state from start-of-frame values: collision, then movement,
    // then spawn/fire (which only look at the start-of-frame actives).
    always_comb begin
        hit     = pea_act && zombie_act && ({1'b0, pea_x} + P_WIDTH >= {1'b0, zombie_x});
        z_alive = zombie_act && !hit;
        p_alive = pea_act && !hit;
        z_moved = {1'b0, zombie_x} - Z_STEP;
        p_moved = {1'b0, pea_x} + P_STEP;

        zombie_act_d = zombie_act;
        zombie_x_d   = zombie_x;
        pea_act_d    = pea_act;
        pea_x_d      = pea_x;

        if (hit) begin
            zombie_act_d = 1'b0;
            pea_act_d    = 1'b0;
        end
        if (z_alive) begin
            zombie_x_d = z_moved[9:0];
        end
        if (p_alive) begin
            // A pea leaving the screen is retired rather than wrapped.
            if (p_moved >= P_LIMIT) begin
                pea_act_d = 1'b0;
            end else begin
                pea_x_d = p_moved[9:0];
            end
        end
        if (spawn && !zombie_act) begin
            zombie_act_d = 1'b1;
            zombie_x_d   = Z_SPAWN_X;
        end
        if (fire && !pea_act) begin
            pea_act_d = 1'b1;
            pea_x_d   = P_START_X;
        end
    end

    assign kill          = hit;
    assign reached_plant = z_alive && (z_moved <= PLANT_EDGE);

    // Lane state register, stepped once per frame while playing.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            zombie_act <= 1'b0;
            zombie_x   <= '0;
            pea_act    <= 1'b0;
            pea_x      <= '0;
        end else if (advance) begin
            zombie_act <= zombie_act_d;
            zombie_x   <= zombie_x_d;
            pea_act    <= pea_act_d;
            pea_x      <= pea_x_d;
        end
    end

endmodule

// File: rtl/zombie_lane_engine.sv
// Top of the lane game: NUM_LANES lane trackers, the PLAY/OVER FSM, a
// saturating kill counter and a registered pixel colour generator.
module zombie_lane_engine
    import pvz_pkg::*;
#(
    parameter int NUM_LANES   = 5,
    parameter int COUNT_W     = 16,
    parameter int LANE_H      = 96,
    parameter int ZOMBIE_STEP = 1,
    parameter int PEA_STEP    = 4,
    parameter int SCREEN_W    = 640,
    parameter int PLANT_X     = 16,
    parameter int PLANT_W     = 32,
    parameter int ZOMBIE_W    = 32,
    parameter int PEA_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 frame_tick,
    input  logic [9:0]           hCount,
    input  logic [9:0]           vCount,
    input  logic                 bright,
    input  logic [NUM_LANES-1:0] spawn,
    input  logic [NUM_LANES-1:0] fire,
    output logic [11:0]          rgb,
    output logic [COUNT_W-1:0]   zombies_killed,
    output logic                 game_over
);

    localparam int KW = $clog2(NUM_LANES + 1);
    localparam int SW = COUNT_W + KW;

    game_state_e          state_q;
    game_state_e          state_d;
    logic                 advance;
    logic [NUM_LANES-1:0] zombie_act;
    logic [NUM_LANES-1:0] pea_act;
    logic [NUM_LANES-1:0] kill;
    logic [NUM_LANES-1:0] reached_plant;
    logic [9:0]           zombie_x [NUM_LANES];
    logic [9:0]           pea_x    [NUM_LANES];
    logic [NUM_LANES-1:0] zombie_pix;
    logic [NUM_LANES-1:0] pea_pix;
    logic                 plant_pix;
    logic [10:0]          sx;
    logic [10:0]          sy;
    logic [KW-1:0]        kill_pop;
    logic [SW-1:0]        count_sum;
    logic [COUNT_W-1:0]   count_next;
    logic [11:0]          pix_colour;

    assign advance   = frame_tick && (state_q == ST_PLAY);
    assign game_over = (state_q == ST_OVER);

    // Screen-relative pixel coordinates; off-screen values are masked by bright.
    assign sx = {1'b0, hCount - H_ORG};
    assign sy = {1'b0, vCount - V_ORG};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam logic [10:0] LANE_TOP = 11'(i * LANE_H);
        localparam logic [10:0] Z_TOP    = LANE_TOP + 11'((LANE_H - ZOMBIE_W) / 2);
        localparam logic [10:0] P_TOP    = LANE_TOP + 11'((LANE_H - PEA_W) / 2);

        lane_tracker #(
            .ZOMBIE_STEP (ZOMBIE_STEP),
            .PEA_STEP    (PEA_STEP),
            .SCREEN_W    (SCREEN_W),
            .PLANT_X     (PLANT_X),
            .PLANT_W     (PLANT_W),
            .ZOMBIE_W    (ZOMBIE_W),
            .PEA_W       (PEA_W)
        ) u_lane (
            .clk           (clk),
            .reset_n       (reset_n),
            .advance       (advance),
            .spawn         (spawn[i]),
            .fire          (fire[i]),
            .zombie_act    (zombie_act[i]),
            .zombie_x      (zombie_x[i]),
            .pea_act       (pea_act[i]),
            .pea_x         (pea_x[i]),
            .kill          (kill[i]),
            .reached_plant (reached_plant[i])
        );

        // Sprites are square and vertically centred in their lane.
        assign zombie_pix[i] = zombie_act[i]
                             && in_span(sy, Z_TOP, 11'(ZOMBIE_W))
                             && in_span(sx, {1'b0, zombie_x[i]}, 11'(ZOMBIE_W));
        assign pea_pix[i]    = pea_act[i]
                             && in_span(sy, P_TOP, 11'(PEA_W))
                             && in_span(sx, {1'b0, pea_x[i]}, 11'(PEA_W));
    end

    assign plant_pix = in_span(sx, 11'(PLANT_X), 11'(PLANT_W))
                    && (sy < 11'(NUM_LANES * LANE_H));

    // Game FSM next state: a zombie reaching the plant column ends the game.
    always_comb begin
        state_d = state_q;
        if ((state_q == ST_PLAY) && frame_tick && (|reached_plant)) begin
            state_d = ST_OVER;
        end
    end

    // Game FSM state register; only reset returns to PLAY.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_PLAY;
        end else begin
            state_q <= state_d;
        end
    end

    // Kills this frame added to the counter with saturation at all-ones.
    always_comb begin
        kill_pop = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            kill_pop = kill_pop + KW'(kill[i]);
        end
        count_sum = SW'(zombies_killed) + SW'(kill_pop);
        if (|count_sum[SW-1:COUNT_W]) begin
            count_next = '1;
        end else begin
            count_next = count_sum[COUNT_W-1:0];
        end
    end

    // Kill counter register, frozen outside PLAY.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            zombies_killed <= '0;
        end else if (advance) begin
            zombies_killed <= count_next;
        end
    end

    // Pixel colour by priority: blanking, game over, zombie, pea, plant, lawn.
    always_comb begin
        pix_colour = COL_LIGHT_GREY;
        if (!bright) begin
            pix_colour = COL_BLACK;
        end else if (state_q == ST_OVER) begin
            pix_colour = COL_RED;
        end else if (|zombie_pix) begin
            pix_colour = COL_GREY;
        end else if (|pea_pix) begin
            pix_colour = COL_GREEN;
        end else if (plant_pix) begin
            pix_colour = COL_PLANT;
        end
    end

    // One-cycle registered colour output.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rgb <= COL_BLACK;
        end else begin
            rgb <= pix_colour;
        end
    end

endmodule

// File: tb/tb_zombie_lane_engine.sv
// Bench for zombie_lane_engine: a default instance plus a COUNT_W=4 instance
// driven by the same stimulus, directed frame sequences and pixel probes.
module tb_zombie_lane_engine;

    logic        clk;
    logic        reset_n;
    logic        frame_tick;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        bright;
    logic [4:0]  spawn;
    logic [4:0]  fire;
    logic [11:0] rgb_a;
    logic [11:0] rgb_b;
    logic [15:0] killed_a;
    logic [3:0]  killed_b;
    logic        over_a;
    logic        over_b;

    int n_checks = 0;
    int n_errors = 0;
    logic [11:0] exp_q[$];

    zombie_lane_engine dut_a (
        .clk            (clk),
        .reset_n        (reset_n),
        .frame_tick     (frame_tick),
        .hCount         (hCount),
        .vCount         (vCount),
        .bright         (bright),
        .spawn          (spawn),
        .fire           (fire),
        .rgb            (rgb_a),
        .zombies_killed (killed_a),
        .game_over      (over_a)
    );

    zombie_lane_engine #(.COUNT_W(4)) dut_b (
        .clk            (clk),
        .reset_n        (reset_n),
        .frame_tick     (frame_tick),
        .hCount         (hCount),
        .vCount         (vCount),
        .bright         (bright),
        .spawn          (spawn),
        .fire           (fire),
        .rgb            (rgb_b),
        .zombies_killed (killed_b),
        .game_over      (over_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One frame: a single-cycle tick with the given requests.
    task automatic frame(input logic [4:0] sp, input logic [4:0] fi);
        @(negedge clk);
        spawn      = sp;
        fire       = fi;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        spawn      = '0;
        fire       = '0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame('0, '0);
    endtask

    // Drive a pixel, queue its colour, compare when the register has caught it.
    task automatic pixel(input string tag, input int h, input int v, input logic b,
                         input logic [11:0] e);
        @(negedge clk);
        hCount = 10'(h);
        vCount = 10'(v);
        bright = b;
        exp_q.push_back(e);
        @(negedge clk);
        check(tag, rgb_a, exp_q.pop_front());
        bright = 1'b0;
    endtask

    // Spawn and fire together on the masked lanes; the pea meets the zombie on
    // the 112th frame after the spawn frame (5 px/frame closing over 552 px).
    task automatic kill_round(input logic [4:0] mask, input bit probe,
                              input int a0, input int b0, input int a1, input int b1);
        frame(mask, mask);
        for (int i = 1; i <= 111; i++) begin
            if (probe && i == 5) begin
                frame(mask, mask);
                check("spawn_ignored_x", dut_a.zombie_x[0], 603);
                check("fire_dropped_x", dut_a.pea_x[0], 68);
            end else begin
                frame('0, '0);
            end
        end
        check("pre_kill_a", killed_a, a0);
        check("pre_kill_b", killed_b, b0);
        frame('0, '0);
        check("kill_a", killed_a, a1);
        check("kill_b", killed_b, b1);
        check("kill_cleared", (dut_a.zombie_act | dut_a.pea_act) & mask, 0);
    endtask

    initial begin
        reset_n    = 1'b0;
        frame_tick = 1'b0;
        hCount     = '0;
        vCount     = '0;
        bright     = 1'b0;
        spawn      = '0;
        fire       = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        check("rst_killed", killed_a, 0);
        check("rst_over", over_a, 0);
        check("rst_rgb", rgb_a, 12'h000);
        check("rst_act", dut_a.zombie_act | dut_a.pea_act, 0);

        // Spawn lane 0 then three frames of walking.
        frame(5'b00001, '0);
        check("spawn_x", dut_a.zombie_x[0], 608);
        frames(3);
        check("walk_x", dut_a.zombie_x[0], 605);
        check("walk_killed", killed_a, 0);

        // Pixel probes on the lane-0 zombie at x=605 (rows 32..63 of lane 0).
        pixel("rgb_zombie", 144 + 605 + 10, 35 + 32 + 5, 1'b1, 12'h0B4);
        pixel("rgb_blank", 144 + 605 + 10, 35 + 32 + 5, 1'b0, 12'h000);
        pixel("rgb_zombie_edge", 144 + 605 + 31, 35 + 40, 1'b1, 12'h0B4);
        pixel("rgb_past_zombie", 144 + 605 + 32, 35 + 40, 1'b1, 12'h332);
        pixel("rgb_lawn", 144 + 300, 35 + 10, 1'b1, 12'h332);
        pixel("rgb_plant", 144 + 20, 35 + 10, 1'b1, 12'h070);

        // Three zombies active, then reset with a tick and requests present.
        frame(5'b00110, '0);
        check("three_active", dut_a.zombie_act, 5'b00111);
        @(negedge clk);
        reset_n    = 1'b0;
        frame_tick = 1'b1;
        spawn      = '1;
        fire       = '1;
        hCount     = 10'(144 + 604 + 4);
        vCount     = 10'(35 + 40);
        bright     = 1'b1;
        @(negedge clk);
        reset_n    = 1'b1;
        frame_tick = 1'b0;
        spawn      = '0;
        fire       = '0;
        bright     = 1'b0;
        check("mid_rst_act", dut_a.zombie_act | dut_a.pea_act, 0);
        for (int i = 0; i < 5; i++) begin
            check("mid_rst_zx", dut_a.zombie_x[i], 0);
            check("mid_rst_px", dut_a.pea_x[i], 0);
        end
        check("mid_rst_over", over_a, 0);
        check("mid_rst_rgb", rgb_a, 12'h000);

        // Lane 2: zombie walked to 60, then a pea fired at 48.
        frame(5'b00100, '0);
        frames(548);
        check("z_at_60", dut_a.zombie_x[2], 60);
        frame('0, 5'b00100);
        check("pea_start", dut_a.pea_x[2], 48);
        check("z_after_fire", dut_a.zombie_x[2], 59);
        pixel("rgb_pea", 144 + 50, 35 + 192 + 44 + 3, 1'b1, 12'h0F0);
        frame('0, '0);
        check("no_kill_yet", killed_a, 0);
        check("pea_moved", dut_a.pea_x[2], 52);
        frame('0, '0);
        check("kill_one", killed_a, 1);
        check("kill_one_b", killed_b, 1);
        check("kill_clear", {dut_a.zombie_act[2], dut_a.pea_act[2]}, 0);

        // Simultaneous kills and saturation of the 4-bit counter.
        kill_round(5'b01010, 1'b0, 1, 1, 3, 3);
        kill_round(5'b11111, 1'b1, 3, 3, 8, 8);
        kill_round(5'b11111, 1'b0, 8, 8, 13, 13);
        kill_round(5'b00011, 1'b0, 13, 13, 15, 15);
        kill_round(5'b00001, 1'b0, 15, 15, 16, 15);

        // A pea with no target is retired at the right edge.
        frame('0, 5'b10000);
        frames(145);
        check("pea_edge_x", dut_a.pea_x[4], 628);
        check("pea_edge_act", dut_a.pea_act[4], 1);
        frame('0, '0);
        check("pea_retired", dut_a.pea_act[4], 0);

        // Unopposed zombie in lane 4 reaches the plant after 560 frames.
        frame(5'b10000, '0);
        frames(559);
        check("not_over_yet", over_a, 0);
        frame('0, '0);
        check("over_a", over_a, 1);
        check("over_b", over_b, 1);
        check("over_zx", dut_a.zombie_x[4], 48);
        frame('1, '1);
        check("frozen_zact", dut_a.zombie_act, 5'b10000);
        check("frozen_pact", dut_a.pea_act, 0);
        check("frozen_zx", dut_a.zombie_x[4], 48);
        check("frozen_killed", killed_a, 16);
        pixel("rgb_over", 144 + 300, 35 + 10, 1'b1, 12'hF00);
        pixel("rgb_over_blank", 144 + 300, 35 + 10, 1'b0, 12'h000);

        do_reset();
        check("exit_over", over_a, 0);
        check("exit_killed", killed_a, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/zombie_lane_engine.md
ZOMBIE_LANE_ENGINE -- requirements
Module: zombie_lane_engine

Interface
REQ-001 Parameter NUM_LANES, default 5: number of independent lanes.
REQ-002 Parameter COUNT_W, default 16: width of the kill counter.
REQ-003 Parameter LANE_H, default 96: lane height in pixels.
REQ-004 Parameter ZOMBIE_STEP, default 1: zombie pixels moved left per frame.
REQ-005 Parameter PEA_STEP, default 4: pea pixels moved right per frame.
REQ-006 Parameter SCREEN_W, default 640: visible width.
REQ-007 Parameters PLANT_X, PLANT_W, ZOMBIE_W, PEA_W, defaults 16, 32, 32, 8: sprite geometry in pixels.
REQ-008 clk  in  1  system clock; one clock; all logic on rising edge.
REQ-009 reset_n  in  1  reset, synchronous, active-low.
REQ-010 frame_tick  in  1  one-cycle pulse, once per frame at vertical blank.
REQ-011 hCount, vCount  in  10 each  pixel counters; visible origin at (144, 35).
REQ-012 bright  in  1  high while the pixel is visible.
REQ-013 spawn  in  NUM_LANES  per-lane zombie spawn request, sampled on frame_tick.
REQ-014 fire  in  NUM_LANES  per-lane pea fire request, sampled on frame_tick.
REQ-015 rgb  out  12  registered pixel colour.
REQ-016 zombies_killed  out  COUNT_W  saturating kill count.
REQ-017 game_over  out  1  high in OVER state.

Function
REQ-018 The global FSM SHALL have two states: PLAY and OVER; only reset SHALL leave OVER.
REQ-019 Each lane SHALL hold zombie_act, zombie_x[9:0], pea_act and pea_x[9:0]; these SHALL change only on a cycle with frame_tick=1 in PLAY.
REQ-020 The per-frame update order, using start-of-frame values, SHALL be: collision, movement, spawn/fire.
REQ-021 Collision: pea_act & zombie_act & (pea_x+PEA_W >= zombie_x) SHALL clear both actives and count one kill for that lane.
REQ-022 Movement: an active zombie SHALL take zombie_x-ZOMBIE_STEP; an active pea SHALL take pea_x+PEA_STEP; a pea whose new x would be >= SCREEN_W-PEA_W SHALL be cleared, never wrapped.
REQ-023 Spawn: spawn[i] with zombie_act=0 at start of frame SHALL set zombie_x=SCREEN_W-ZOMBIE_W; a request on a lane that was occupied or killed this frame SHALL be ignored.
REQ-024 Fire: fire[i] with pea_act=0 at start of frame SHALL set pea_x=PLANT_X+PLANT_W; a request while a pea is in flight SHALL be dropped.
REQ-025 Kills from several lanes in one frame SHALL add their popcount to zombies_killed, saturating at all-ones.
REQ-026 A surviving zombie whose post-move x is <= PLANT_X+PLANT_W SHALL move the FSM to OVER on that edge; all lane state and the counter SHALL then freeze.
REQ-027 rgb SHALL have exactly 1 cycle of latency from hCount/vCount/bright.
REQ-028 rgb priority SHALL be: bright=0 -> 12'h000; OVER -> 12'hF00; zombie sprite -> GREY 12'h0B4; pea -> GREEN 12'h0F0; plant column -> 12'h070; otherwise LIGHT_GREY 12'h332.
REQ-029 Lane i SHALL span rows V_ORG+i*LANE_H to V_ORG+(i+1)*LANE_H-1; sprites SHALL be vertically centred, with ZOMBIE_W and PEA_W as their heights.

Reset
REQ-030 With reset_n=0 at a clock edge, the block SHALL clear all actives, set every x to 0, set zombies_killed=0, game_over=0, rgb=0 and the FSM to PLAY, regardless of frame_tick or current state.

Structure
REQ-031 Package pvz_pkg SHALL hold the colour constants, H_ORG/V_ORG and the FSM state typedef.
REQ-032 Per-lane state and update logic SHALL live in sub-module lane_tracker, instantiated NUM_LANES times by generate; it SHALL output kill and reached_plant.

Verification
REQ-033 Spawn lane 0, then 3 frame_ticks -> zombie_x = 605, zombies_killed = 0.
REQ-034 Zombie at x=60 and pea fired at 48 in lane 2 -> kill on the frame where pea_x+8 >= zombie_x; both cleared; counter +1.
REQ-035 Kills in lanes 1 and 3 in the same frame -> counter +2; with COUNT_W=4 preloaded by 15 kills, a 16th kill -> stays 15.
REQ-036 Spawn lane 4, no fire -> game_over=1 after 560 frame_ticks; further spawn/fire ignored; rgb=12'hF00 on visible pixels.
REQ-037 Assert reset_n=0 mid-play with 3 zombies active -> next cycle all state zero, FSM PLAY.
REQ-038 Drive hCount/vCount onto a zombie pixel -> rgb=12'h0B4 one cycle later; same pixel with bright=0 -> 12'h000.
